dma_cpu_reg_if: RTL and testbench

DMA_CPU_REG_IF -- requirements
Module: dma_cpu_reg_if

---
 rtl/dma_cpu_reg_if.sv | 179 +++++++++++++++++
 tb/tb_dma_cpu_reg_if.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cpu_reg_if.sv
// CPU-side register file of a four-channel DMA controller: byte-wide access to
// 16-bit address/count registers, command/mode/mask/request state and status.
module dma_cpu_reg_if (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CS_N,
    input  logic        IOR_N,
    input  logic        IOW_N,
    input  logic [3:0]  A,
    input  logic [7:0]  DB_IN,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    input  logic [3:0]  hw_dreq,
    input  logic [3:0]  tc_set,
    input  logic        upd_en,
    input  logic [1:0]  upd_ch,
    input  logic [15:0] upd_addr,
    input  logic [15:0] upd_count,
    input  logic        tmp_ld,
    input  logic [7:0]  tmp_din,
    output logic [7:0]  command_o,
    output logic [23:0] mode_o,
    output logic [3:0]  mask_o,
    output logic [3:0]  sw_req_o,
    output logic [63:0] base_addr_o,
    output logic [63:0] base_count_o,
    output logic [63:0] cur_addr_o,
    output logic [63:0] cur_count_o
);

    logic [15:0] baseAddr  [4];
    logic [15:0] baseCount [4];
    logic [15:0] curAddr   [4];
    logic [15:0] curCount  [4];
    logic [5:0]  modeReg   [4];
    logic [3:0]  tcFlag;
    logic [7:0]  tempReg;
    logic        bytePtr;
    logic        iorPrev;
    logic        iowPrev;

    logic        rdStart;
    logic        wrStart;
    logic        chanAcc;
    logic [1:0]  ch;
    logic        statusRd;
    logic [7:0]  statusByte;
    logic [7:0]  rdData;
    logic [15:0] rdWord;

    // Strobe history resets low so a strobe held through reset must rise first.
    assign rdStart  = !CS_N && !IOR_N && IOW_N && iorPrev;
    assign wrStart  = !CS_N && !IOW_N && IOR_N && iowPrev;
    assign chanAcc  = !A[3];
    assign ch       = A[2:1];
    assign statusRd = rdStart && (A == 4'h8);

    always_comb begin
        statusByte = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            statusByte[7-i] = tcFlag[i];
            statusByte[3-i] = hw_dreq[i] | sw_req_o[i];
        end
    end

    always_comb begin
        rdWord = A[0] ? curCount[ch] : curAddr[ch];
        rdData = '0;
        if (chanAcc)
            rdData = bytePtr ? rdWord[15:8] : rdWord[7:0];
        else if (A[2:0] == 3'd0)
            rdData = statusByte;
        else if (A[2:0] == 3'd5)
            rdData = tempReg;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < 4; i++) begin
                baseAddr[i]  <= '0;
                baseCount[i] <= '0;
                curAddr[i]   <= '0;
                curCount[i]  <= '0;
                modeReg[i]   <= '0;
            end
            command_o <= '0;
            mask_o    <= '1;
            sw_req_o  <= '0;
            tcFlag    <= '0;
            tempReg   <= '0;
            bytePtr   <= 1'b0;
            iorPrev   <= 1'b0;
            iowPrev   <= 1'b0;
            DB_OUT    <= '0;
            DB_OE     <= 1'b0;
        end else begin
            iorPrev <= IOR_N;
            iowPrev <= IOW_N;

            if (tmp_ld)
                tempReg <= tmp_din;

            tcFlag   <= (statusRd ? 4'h0 : tcFlag) | tc_set;
            sw_req_o <= sw_req_o & ~tc_set;

            // A CPU write to this channel's address/count drops the whole engine update.
            if (upd_en && !(wrStart && chanAcc && ch == upd_ch)) begin
                curAddr[upd_ch]  <= upd_addr;
                curCount[upd_ch] <= upd_count;
            end

            if (rdStart) begin
                DB_OUT <= rdData;
                DB_OE  <= 1'b1;
                if (chanAcc)
                    bytePtr <= !bytePtr;
            end else if (IOR_N || CS_N || !IOW_N) begin
                DB_OE <= 1'b0;
            end

            if (wrStart) begin
                if (chanAcc) begin
                    if (!A[0]) begin
                        if (bytePtr) begin
                            baseAddr[ch][15:8] <= DB_IN;
                            curAddr[ch][15:8]  <= DB_IN;
                        end else begin
                            baseAddr[ch][7:0]  <= DB_IN;
                            curAddr[ch][7:0]   <= DB_IN;
                        end
                    end else begin
                        if (bytePtr) begin
                            baseCount[ch][15:8] <= DB_IN;
                            curCount[ch][15:8]  <= DB_IN;
                        end else begin
                            baseCount[ch][7:0]  <= DB_IN;
                            curCount[ch][7:0]   <= DB_IN;
                        end
                    end
                    bytePtr <= !bytePtr;
                end else begin
                    case (A[2:0])
                        3'd0: command_o <= DB_IN;
                        3'd1: sw_req_o[DB_IN[2:1]] <= DB_IN[0];
                        3'd2: mask_o[DB_IN[2:1]] <= DB_IN[0];
                        3'd3: modeReg[DB_IN[7:6]] <= DB_IN[5:0];
                        3'd4: bytePtr <= 1'b0;
                        3'd5: begin
                            command_o <= '0;
                            tcFlag    <= '0;
                            tempReg   <= '0;
                            sw_req_o  <= '0;
                            bytePtr   <= 1'b0;
                            mask_o    <= '1;
                        end
                        3'd6: mask_o <= '0;
                        3'd7: mask_o <= {DB_IN[0], DB_IN[1], DB_IN[2], DB_IN[3]};
                    endcase
                end
            end
        end
    end

    always_comb begin
        mode_o       = '0;
        base_addr_o  = '0;
        base_count_o = '0;
        cur_addr_o   = '0;
        cur_count_o  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            mode_o[i*6 +: 6]        = modeReg[i];
            base_addr_o[i*16 +: 16]  = baseAddr[i];
            base_count_o[i*16 +: 16] = baseCount[i];
            cur_addr_o[i*16 +: 16]   = curAddr[i];
            cur_count_o[i*16 +: 16]  = curCount[i];
        end
    end

endmodule

// File: tb/tb_dma_cpu_reg_if.sv
// Bench for dma_cpu_reg_if: directed vector table, multi-cycle corner sequences
// and random bus traffic checked against a transaction-level register model.
module tb_dma_cpu_reg_if;

    logic        CLK = 1'b0;
    logic        RESET, CS_N, IOR_N, IOW_N;
    logic [3:0]  A;
    logic [7:0]  DB_IN, DB_OUT;
    logic        DB_OE;
    logic [3:0]  hw_dreq, tc_set;
    logic        upd_en;
    logic [1:0]  upd_ch;
    logic [15:0] upd_addr, upd_count;
    logic        tmp_ld;
    logic [7:0]  tmp_din;
    logic [7:0]  command_o;
    logic [23:0] mode_o;
    logic [3:0]  mask_o, sw_req_o;
    logic [63:0] base_addr_o, base_count_o, cur_addr_o, cur_count_o;

    int checks = 0;
    int errors = 0;

    dma_cpu_reg_if dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .A(A), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .hw_dreq(hw_dreq), .tc_set(tc_set),
        .upd_en(upd_en), .upd_ch(upd_ch), .upd_addr(upd_addr), .upd_count(upd_count),
        .tmp_ld(tmp_ld), .tmp_din(tmp_din),
        .command_o(command_o), .mode_o(mode_o), .mask_o(mask_o), .sw_req_o(sw_req_o),
        .base_addr_o(base_addr_o), .base_count_o(base_count_o),
        .cur_addr_o(cur_addr_o), .cur_count_o(cur_count_o)
    );

    always #5 CLK = ~CLK;

    // Reference model state, one word per register
    logic [15:0] mBaseA [4];
    logic [15:0] mBaseC [4];
    logic [15:0] mCurA  [4];
    logic [15:0] mCurC  [4];
    logic [5:0]  mMode  [4];
    logic [7:0]  mCmd, mTmp;
    logic [3:0]  mMask, mSw, mTc;
    logic        mPtr;

    typedef struct {
        bit         wr;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mReset();
        for (int i = 0; i < 4; i++) begin
            mBaseA[i] = 0; mBaseC[i] = 0; mCurA[i] = 0; mCurC[i] = 0; mMode[i] = 0;
        end
        mCmd = 0; mTmp = 0; mMask = 4'hF; mSw = 0; mTc = 0; mPtr = 0;
    endtask

    function automatic logic [15:0] putByte(input logic [15:0] w, input logic [7:0] d, input logic hi);
        return hi ? {d, w[7:0]} : {w[15:8], d};
    endfunction

    function automatic logic [7:0] mStatus();
        logic [7:0] s = 0;
        for (int c = 0; c < 4; c++) begin
            s[7-c] = mTc[c];
            s[3-c] = hw_dreq[c] | mSw[c];
        end
        return s;
    endfunction

    task automatic mWrite(input logic [3:0] a, input logic [7:0] d);
        int c;
        c = int'(a[2:1]);
        if (!a[3]) begin
            if (!a[0]) begin
                mBaseA[c] = putByte(mBaseA[c], d, mPtr);
                mCurA[c]  = putByte(mCurA[c], d, mPtr);
            end else begin
                mBaseC[c] = putByte(mBaseC[c], d, mPtr);
                mCurC[c]  = putByte(mCurC[c], d, mPtr);
            end
            mPtr = !mPtr;
        end else begin
            case (a)
                4'h8: mCmd = d;
                4'h9: mSw[d[2:1]] = d[0];
                4'hA: mMask[d[2:1]] = d[0];
                4'hB: mMode[d[7:6]] = d[5:0];
                4'hC: mPtr = 0;
                4'hD: begin mCmd = 0; mTc = 0; mTmp = 0; mSw = 0; mPtr = 0; mMask = 4'hF; end
                4'hE: mMask = 0;
                4'hF: for (int k = 0; k < 4; k++) mMask[k] = d[3-k];
                default: ;
            endcase
        end
    endtask

    task automatic mRead(input logic [3:0] a, output logic [7:0] exp);
        logic [15:0] w;
        exp = 0;
        if (!a[3]) begin
            w = a[0] ? mCurC[a[2:1]] : mCurA[a[2:1]];
            exp = mPtr ? w[15:8] : w[7:0];
            mPtr = !mPtr;
        end else if (a == 4'h8) begin
            exp = mStatus();
            mTc = 0;
        end else if (a == 4'hD) begin
            exp = mTmp;
        end
    endtask

    task automatic cpuWrite(input logic [3:0] a, input logic [7:0] d);
        CS_N = 0; IOW_N = 0; A = a; DB_IN = d;
        tick();
        IOW_N = 1; CS_N = 1;
        tick();
    endtask

    task automatic cpuRead(input logic [3:0] a, output logic [7:0] d);
        CS_N = 0; IOR_N = 0; A = a;
        tick();
        d = DB_OUT;
        chk("db_oe_on", DB_OE, 1);
        IOR_N = 1; CS_N = 1;
        tick();
        chk("db_oe_off", DB_OE, 0);
    endtask

    task automatic pulseTc(input logic [3:0] v);
        tc_set = v;
        tick();
        tc_set = 0;
        mTc = mTc | v;
        mSw = mSw & ~v;
    endtask

    task automatic checkRegs(input string tag);
        logic [23:0] em;
        logic [63:0] eba, ebc, eca, ecc;
        for (int i = 0; i < 4; i++) begin
            em[i*6 +: 6]   = mMode[i];
            eba[i*16 +: 16] = mBaseA[i];
            ebc[i*16 +: 16] = mBaseC[i];
            eca[i*16 +: 16] = mCurA[i];
            ecc[i*16 +: 16] = mCurC[i];
        end
        chk({tag, ".command"}, command_o, mCmd);
        chk({tag, ".mode"}, mode_o, em);
        chk({tag, ".mask"}, mask_o, mMask);
        chk({tag, ".sw_req"}, sw_req_o, mSw);
        chk({tag, ".base_addr"}, base_addr_o, eba);
        chk({tag, ".base_count"}, base_count_o, ebc);
        chk({tag, ".cur_addr"}, cur_addr_o, eca);
        chk({tag, ".cur_count"}, cur_count_o, ecc);
    endtask

    initial begin
        logic [7:0] d, e;
        logic [3:0] a;
        int c;

        RESET = 1; CS_N = 1; IOR_N = 1; IOW_N = 1; A = 0; DB_IN = 0;
        hw_dreq = 0; tc_set = 0; upd_en = 0; upd_ch = 0; upd_addr = 0; upd_count = 0;
        tmp_ld = 0; tmp_din = 0;
        mReset();
        tick(); tick();
        RESET = 0;
        tick();

        chk("reset.db_oe", DB_OE, 0);
        chk("reset.db_out", DB_OUT, 0);
        checkRegs("reset");

        vecs = '{
            '{1, 4'hC, 8'h00, 8'h00},
            '{1, 4'h2, 8'h34, 8'h00},
            '{1, 4'h2, 8'h12, 8'h00},
            '{0, 4'h2, 8'h00, 8'h34},
            '{0, 4'h2, 8'h00, 8'h12},
            '{1, 4'hB, 8'hC5, 8'h00},
            '{1, 4'h0, 8'hAA, 8'h00},
            '{1, 4'hC, 8'h00, 8'h00},
            '{0, 4'h0, 8'h00, 8'hAA},
            '{1, 4'hC, 8'h00, 8'h00},
            '{0, 4'hD, 8'h00, 8'h00},
            '{0, 4'h9, 8'h00, 8'h00},
            '{1, 4'hF, 8'h05, 8'h00},
            '{0, 4'h8, 8'h00, 8'h00},
            '{0, 4'hA, 8'h00, 8'h00}
        };
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                cpuWrite(vecs[i].a, vecs[i].d);
                mWrite(vecs[i].a, vecs[i].d);
            end else begin
                cpuRead(vecs[i].a, d);
                mRead(vecs[i].a, e);
                chk($sformatf("vec%0d.read", i), d, vecs[i].exp);
            end
        end
        chk("vec.base_addr_ch1", base_addr_o[31:16], 16'h1234);
        chk("vec.cur_addr_ch1", cur_addr_o[31:16], 16'h1234);
        chk("vec.mode_ch3", mode_o[23:18], 6'h05);
        chk("vec.mask", mask_o, 4'hA);
        checkRegs("vec");

        // Terminal-count flag captured then cleared by status read
        pulseTc(4'b0100);
        cpuRead(4'h8, d); mRead(4'h8, e);
        chk("tc.status1", d, 8'h20);
        cpuRead(4'h8, d); mRead(4'h8, e);
        chk("tc.status2", d, 8'h00);

        // CPU count write beats same-cycle engine update; tc_set beats status clear
        cpuWrite(4'hC, 8'h00); mWrite(4'hC, 8'h00);
        CS_N = 0; IOW_N = 0; A = 4'h3; DB_IN = 8'h77;
        upd_en = 1; upd_ch = 1; upd_addr = 16'hA5A5; upd_count = 16'hBEEF;
        tick();
        upd_en = 0; IOW_N = 1; CS_N = 1;
        tick();
        mWrite(4'h3, 8'h77);
        chk("upd.cur_count_ch1", cur_count_o[31:16], {mCurC[1][15:8], 8'h77});
        checkRegs("upd");
        e = mStatus();
        CS_N = 0; IOR_N = 0; A = 4'h8; tc_set = 4'b0001;
        tick();
        tc_set = 0;
        chk("tcrace.capture", DB_OUT, e);
        tick();
        chk("tcrace.hold", DB_OUT, e);
        IOR_N = 1; CS_N = 1;
        tick();
        mTc = 4'b0001; mSw[0] = 0;
        cpuRead(4'h8, d); mRead(4'h8, e);
        chk("tcrace.bit7", d[7], 1'b1);
        chk("tcrace.status", d, e);

        // Master clear, then both strobes low together must be ignored
        cpuWrite(4'h8, 8'h5A); mWrite(4'h8, 8'h5A);
        cpuWrite(4'hE, 8'h00); mWrite(4'hE, 8'h00);
        cpuWrite(4'hD, 8'h00); mWrite(4'hD, 8'h00);
        chk("mclr.mask", mask_o, 4'hF);
        chk("mclr.command", command_o, 8'h00);
        checkRegs("mclr");
        CS_N = 0; IOR_N = 0; IOW_N = 0; A = 4'hE; DB_IN = 8'h00;
        tick(); tick();
        chk("both.db_oe", DB_OE, 0);
        IOR_N = 1; IOW_N = 1; CS_N = 1;
        tick();
        checkRegs("both");

        // Strobe held low for several cycles is one access
        CS_N = 0; IOW_N = 0; A = 4'h4; DB_IN = 8'h3C;
        tick(); tick(); tick();
        IOW_N = 1; CS_N = 1;
        tick();
        mWrite(4'h4, 8'h3C);
        cpuRead(4'h4, d); mRead(4'h4, e);
        chk("hold.read", d, e);
        checkRegs("hold");

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    a = 4'($urandom_range(0, 15)); d = 8'($urandom);
                    cpuWrite(a, d); mWrite(a, d);
                end
                3, 4, 5: begin
                    a = 4'($urandom_range(0, 15));
                    mRead(a, e);
                    cpuRead(a, d);
                    chk($sformatf("rnd.read%0h", a), d, e);
                end
                6: pulseTc(4'($urandom));
                7: begin
                    c = $urandom_range(0, 3);
                    upd_en = 1; upd_ch = 2'(c);
                    upd_addr = 16'($urandom); upd_count = 16'($urandom);
                    tick();
                    upd_en = 0;
                    mCurA[c] = upd_addr; mCurC[c] = upd_count;
                end
                8: begin
                    tmp_ld = 1; tmp_din = 8'($urandom);
                    tick();
                    tmp_ld = 0; mTmp = tmp_din;
                end
                default: hw_dreq = 4'($urandom);
            endcase
            if (n % 25 == 24) checkRegs("rnd");
        end

        // Reset in the middle of accesses; strobes still low afterwards
        RESET = 1; CS_N = 0; IOR_N = 0; A = 4'h8;
        tick(); tick();
        RESET = 0;
        tick(); tick();
        chk("rstmid.rd_db_oe", DB_OE, 0);
        IOR_N = 1; CS_N = 1;
        tick();
        RESET = 1; CS_N = 0; IOW_N = 0; A = 4'hE; DB_IN = 8'h00;
        tick();
        RESET = 0;
        tick(); tick();
        chk("rstmid.wr_mask", mask_o, 4'hF);
        IOW_N = 1; CS_N = 1;
        tick();
        mReset();
        chk("rstmid.db_out", DB_OUT, 0);
        checkRegs("rstmid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
